// File: rtl/fetch_wait_stage_pkg.sv
// Shared types for the IF_wait stage: exception codes, slot state encoding and queue entry layout.
// The optional IF_WAIT_PERFCNT_EN build adds a wait-for-data cycle counter to fetch_wait_stage.
package fetch_wait_stage_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        IFW_IDLE = 2'd0,
        IFW_WAIT = 2'd1,
        IFW_DROP = 2'd2,
        IFW_HOLD = 2'd3
    } ifw_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic        exc_miss;
        logic [4:0]  exccode;
    } ifw_entry_t;

    localparam int IFW_ENTRY_W = $bits(ifw_entry_t);

    function automatic ifw_entry_t ifw_entry(input logic [31:0] pc, input logic [31:0] inst,
                                             input logic exc, input logic exc_miss,
                                             input logic [4:0] exccode);
        ifw_entry_t e;
        e.pc       = pc;
        e.inst     = inst;
        e.exc      = exc;
        e.exc_miss = exc_miss;
        e.exccode  = exccode;
        return e;
    endfunction

endpackage

// File: rtl/fetch_wait_queue.sv
// Synchronous show-ahead FIFO of completed fetch entries, with flush and a full flag that
// already accounts for a dequeue happening in the same cycle.
module fetch_wait_queue
    import fetch_wait_stage_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int QPTR_W = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush_i,
    input  logic                   enq_i,
    input  logic [IFW_ENTRY_W-1:0] enq_data_i,
    input  logic                   deq_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [IFW_ENTRY_W-1:0] head_o
);

    localparam logic [QPTR_W:0] DEPTH_C = (QPTR_W + 1)'(QDEPTH);

    logic [QPTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [QPTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [QPTR_W:0]      count_q, count_d;
    logic [QPTR_W:0]      count_post;
    logic                 deq_eff;
    logic                 enq_eff;
    logic [IFW_ENTRY_W-1:0] mem_q [QDEPTH];

    always_comb begin
        empty_o    = (count_q == '0);
        deq_eff    = deq_i && !empty_o && !flush_i;
        count_post = count_q - (QPTR_W + 1)'(deq_eff);
        full_o     = (count_post == DEPTH_C);
        enq_eff    = enq_i && !full_o && !flush_i;
        head_o     = empty_o ? '0 : mem_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q + QPTR_W'(enq_eff);
        rd_ptr_d = rd_ptr_q + QPTR_W'(deq_eff);
        count_d  = count_post + (QPTR_W + 1)'(enq_eff);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head_o is forced to zero whenever the count is zero.
    always_ff @(posedge clk) begin
        if (enq_eff) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/fetch_wait_stage.sv
// IF_wait stage: tracks one outstanding fetch, drops flushed responses, queues results for ID.
// Define IF_WAIT_PERFCNT_EN to add the perfcnt_fetch_waitdata cycle counter output.
module fetch_wait_stage
    import fetch_wait_stage_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int QPTR_W = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        cancelled_i,
    input  logic        exc_i,
    input  logic        exc_miss_i,
    input  logic [4:0]  exccode_i,
    output logic        ready_o,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        commit_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    input  logic        ready_i,
    output logic [1:0]  dbg_state_o
`ifdef IF_WAIT_PERFCNT_EN
    ,
    output logic [31:0] perfcnt_fetch_waitdata
`endif
);

    // Handshakes: an entry moves on a cycle where valid and ready are both high at the clock
    // edge; valid never waits on ready, and ready_o may depend on same-cycle inst_data_ok.

    ifw_state_e state_q, state_d;
    ifw_entry_t hold_q, hold_d;
    ifw_entry_t enq_data;
    ifw_entry_t head;
    logic       enq;
    logic       accept;
    logic       q_full;
    logic       q_empty;

    fetch_wait_queue #(
        .QDEPTH (QDEPTH),
        .QPTR_W (QPTR_W)
    ) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .flush_i    (commit_i),
        .enq_i      (enq),
        .enq_data_i (enq_data),
        .deq_i      (ready_i),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .head_o     (head)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        enq      = 1'b0;
        enq_data = hold_q;
        ready_o  = 1'b0;

        case (state_q)
            IFW_IDLE: ready_o = 1'b1;
            IFW_WAIT: begin
                ready_o = inst_data_ok && !q_full;
                if (inst_data_ok && !commit_i) begin
                    if (!q_full) begin
                        enq      = 1'b1;
                        enq_data = ifw_entry(hold_q.pc, inst_rdata, 1'b0, 1'b0, 5'd0);
                        state_d  = IFW_IDLE;
                    end else begin
                        hold_d.inst = inst_rdata;
                        state_d     = IFW_HOLD;
                    end
                end else if (commit_i) begin
                    state_d = inst_data_ok ? IFW_IDLE : IFW_DROP;
                end
            end
            IFW_DROP: begin
                ready_o = inst_data_ok;
                if (inst_data_ok) begin
                    state_d = IFW_IDLE;
                end
            end
            IFW_HOLD: begin
                if (commit_i) begin
                    state_d = IFW_IDLE;
                end else if (!q_full) begin
                    enq     = 1'b1;
                    state_d = IFW_IDLE;
                end
            end
            default: state_d = IFW_IDLE;
        endcase

        // A newly accepted entry always starts from IDLE, even when the slot frees this cycle.
        accept = valid_i && ready_o;
        if (accept) begin
            if (exc_i) begin
                if (!cancelled_i && !commit_i) begin
                    hold_d  = ifw_entry(pc_i, 32'd0, 1'b1, exc_miss_i, exccode_i);
                    state_d = IFW_HOLD;
                end else begin
                    state_d = IFW_IDLE;
                end
            end else begin
                hold_d  = ifw_entry(pc_i, 32'd0, 1'b0, 1'b0, 5'd0);
                state_d = (cancelled_i || commit_i) ? IFW_DROP : IFW_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IFW_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign valid_o     = !q_empty;
    assign pc_o        = head.pc;
    assign inst_o      = head.inst;
    assign exc_o       = head.exc;
    assign exc_miss_o  = head.exc_miss;
    assign exccode_o   = head.exccode;
    assign dbg_state_o = state_q;

`ifdef IF_WAIT_PERFCNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q + 32'((state_q == IFW_WAIT) && !inst_data_ok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perfcnt_fetch_waitdata = perf_q;
`endif

endmodule
